// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: sequencer/arbiter that shares one single-cycle combinational
// ALU between two requesters. One operation is in flight at a time:
//   IDLE --(req)--> EXEC (gnt pulse, ALU driven) --> DONE (done pulse) --> IDLE
// Build option: define ALU_SHARE_RR_EN for round-robin arbitration between the
// two ports; otherwise port 0 has fixed priority over port 1.
module alu_share_ctrl (
    input  logic        clk,
    input  logic        reset,
    // port 0 (main datapath)
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [4:0]  s0,
    input  logic [1:0]  op0,
    // port 1 (auxiliary unit)
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [4:0]  s1,
    input  logic [1:0]  op1,
    // handshake back to the requesters
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        zero,
    output logic        dayuling,
    output logic        busy,
    // shared ALU instance
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_s,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_dayuling
);

    localparam int NPORT = 2;
    localparam int DW    = 32;
    localparam int SW    = 5;
    localparam int OW    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Per-port views of the request inputs, so the rest of the logic can
    // index by port number instead of naming each port separately.
    // ------------------------------------------------------------------
    logic [NPORT-1:0] req_vec;
    logic [DW-1:0]    a_arr  [NPORT];
    logic [DW-1:0]    b_arr  [NPORT];
    logic [SW-1:0]    s_arr  [NPORT];
    logic [OW-1:0]    op_arr [NPORT];

    assign req_vec   = {req1, req0};
    assign a_arr[0]  = a0;
    assign a_arr[1]  = a1;
    assign b_arr[0]  = b0;
    assign b_arr[1]  = b1;
    assign s_arr[0]  = s0;
    assign s_arr[1]  = s1;
    assign op_arr[0] = op0;
    assign op_arr[1] = op1;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           state_reg,  state_next;
    logic             owner_reg;
    logic [NPORT-1:0] gnt_reg,    gnt_next;
    logic [NPORT-1:0] done_reg,   done_next;
    logic             busy_reg;
    logic [DW-1:0]    result_reg;
    logic             zero_reg;
    logic             dayuling_reg;
    logic [DW-1:0]    alu_a_reg;
    logic [DW-1:0]    alu_b_reg;
    logic [SW-1:0]    alu_s_reg;
    logic [OW-1:0]    alu_op_reg;

    // Control strobes from the FSM
    logic             grant_fire;   // accept the winner this edge
    logic             done_fire;    // capture the ALU result this edge

    // Arbitration result (only meaningful when some request is present)
    logic             winner;

    // Operand mux output for the winning port
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;
    logic [SW-1:0]    sel_s;
    logic [OW-1:0]    sel_op;

`ifdef ALU_SHARE_RR_EN
    // Most recently granted port; starts at 1 so the first contention
    // after reset favours port 0.
    logic             last_reg;

    // Round-robin pick: under contention the port that was not served last
    // wins; a lone requester always wins.
    always_comb begin
        winner = 1'b0;
        if (req_vec[0] && req_vec[1]) begin
            winner = ~last_reg;
        end else if (req_vec[1]) begin
            winner = 1'b1;
        end
    end

    // Track the last granted port so contention alternates.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (grant_fire) begin
            last_reg <= winner;
        end
    end
`else
    // Fixed priority pick: port 0 wins whenever it asks; port 1 only
    // gets the ALU when port 0 is quiet.
    always_comb begin
        winner = 1'b0;
        if (!req_vec[0] && req_vec[1]) begin
            winner = 1'b1;
        end
    end
`endif

    // Select the winning port's operands for latching into the ALU inputs.
    always_comb begin
        sel_a  = a_arr[winner];
        sel_b  = b_arr[winner];
        sel_s  = s_arr[winner];
        sel_op = op_arr[winner];
    end

    // Next-state logic: one operation per IDLE->EXEC->DONE pass. Requests
    // are only looked at in IDLE; anything still high during DONE is picked
    // up again on the following IDLE cycle.
    always_comb begin
        state_next = state_reg;
        grant_fire = 1'b0;
        done_fire  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    grant_fire = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                done_fire  = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Per-port pulse generation: the grant goes to the port that won in
    // IDLE, the done pulse to the port recorded as owner of the operation.
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign gnt_next[gi]  = grant_fire && (winner == 1'(gi));
            assign done_next[gi] = done_fire  && (owner_reg == 1'(gi));
        end
    endgenerate

    // State register and one-cycle handshake pulses; reset aborts any
    // operation in flight without issuing its done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            done_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            busy_reg  <= (state_next != ST_IDLE);
        end
    end

    // Operand latch: the ALU inputs are loaded once at grant and then held,
    // so the combinational ALU sees stable values for the whole EXEC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_s_reg  <= '0;
            alu_op_reg <= '0;
            owner_reg  <= 1'b0;
        end else if (grant_fire) begin
            alu_a_reg  <= sel_a;
            alu_b_reg  <= sel_b;
            alu_s_reg  <= sel_s;
            alu_op_reg <= sel_op;
            owner_reg  <= winner;
        end
    end

    // Result capture at the end of EXEC; held until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            dayuling_reg <= 1'b0;
        end else if (done_fire) begin
            result_reg   <= alu_out;
            zero_reg     <= alu_zero;
            dayuling_reg <= alu_dayuling;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign gnt0     = gnt_reg[0];
    assign gnt1     = gnt_reg[1];
    assign done0    = done_reg[0];
    assign done1    = done_reg[1];
    assign busy     = busy_reg;
    assign result   = result_reg;
    assign zero     = zero_reg;
    assign dayuling = dayuling_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign alu_s    = alu_s_reg;
    assign alu_op   = alu_op_reg;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: directed and randomized operations checked
// against a behavioural model of arbitration and ALU arithmetic.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic [4:0]  s0, s1;
    logic [1:0]  op0, op1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] result;
    logic        zero, dayuling, busy;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_s;
    logic [1:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zero, alu_dayuling;

    int          vectors = 0;
    int          miscompares = 0;
    logic        model_last;     // last granted port, as the model sees it

    alu_share_ctrl dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .s0(s0), .op0(op0),
        .req1(req1), .a1(a1), .b1(b1), .s1(s1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .zero(zero), .dayuling(dayuling), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_dayuling(alu_dayuling)
    );

    always #5 clk = ~clk;

    // Reference arithmetic for the four op codes.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] s, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a | b;
            default: return b << s;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU instance.
    always_comb begin
        alu_out      = ref_alu(alu_a, alu_b, alu_s, alu_op);
        alu_zero     = (alu_out == 32'd0);
        alu_dayuling = ($signed(alu_out) > 0);
    end

    // Which port the model expects to be granted for a given request pair.
    function automatic logic pick(input logic r0, input logic r1);
`ifdef ALU_SHARE_RR_EN
        if (r0 && r1) return ~model_last;
`endif
        return r0 ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete operation from IDLE: both requests drop on the grant.
    task automatic transact(input logic r0, input logic r1, input string name);
        logic        w;
        logic [31:0] wa, wb, er;
        logic [4:0]  ws;
        logic [1:0]  wo;
        w  = pick(r0, r1);
        wa = w ? a1 : a0;
        wb = w ? b1 : b0;
        ws = w ? s1 : s0;
        wo = w ? op1 : op0;
        er = ref_alu(wa, wb, ws, wo);
        req0 = r0;
        req1 = r1;
        tick;  // EXEC
        check({name, " exec gnt"}, {gnt1, gnt0}, w ? 32'd2 : 32'd1);
        check({name, " exec done"}, {done1, done0}, 32'd0);
        check({name, " exec busy"}, busy, 32'd1);
        check({name, " alu_a"}, alu_a, wa);
        check({name, " alu_b"}, alu_b, wb);
        check({name, " alu_op"}, alu_op, wo);
        if (wo == 2'b11) check({name, " alu_s"}, alu_s, ws);
        model_last = w;
        req0 = 1'b0;
        req1 = 1'b0;
        tick;  // DONE
        check({name, " done pulse"}, {done1, done0}, w ? 32'd2 : 32'd1);
        check({name, " done gnt"}, {gnt1, gnt0}, 32'd0);
        check({name, " done busy"}, busy, 32'd1);
        check({name, " result"}, result, er);
        check({name, " zero"}, zero, er == 32'd0);
        check({name, " dayuling"}, dayuling, $signed(er) > 0);
        tick;  // IDLE
        check({name, " idle busy"}, busy, 32'd0);
        check({name, " idle pulses"}, {gnt1, gnt0, done1, done0}, 32'd0);
        check({name, " result held"}, result, er);
        $display("txn %s port=%0d op=%0d a=%h b=%h s=%0d result=%h", name, w, wo, wa, wb, ws, result);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [31:0] er;
        logic [1:0]  pat;

        reset = 1'b1;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; s0 = 0; op0 = 0;
        a1 = 0; b1 = 0; s1 = 0; op1 = 0;
        model_last = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        tick;
        check("reset pulses", {gnt1, gnt0, done1, done0, busy}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {zero, dayuling}, 32'd0);
        check("reset alu", {alu_a ^ alu_b, 25'd0, alu_s, alu_op} | {31'd0, |alu_a}, 64'd0);

        // Directed cases
        a0 = 5; b0 = 7; op0 = 2'b00;
        transact(1, 0, "add5+7");
        a1 = 3; b1 = 3; op1 = 2'b01;
        transact(0, 1, "sub3-3");
        a0 = 32'h1234; b0 = 1; s0 = 31; op0 = 2'b11;
        transact(1, 0, "shl31");
        a0 = 32'hF0; b0 = 32'h0F; op0 = 2'b10;
        transact(1, 0, "orF0");

        // Reset in the EXEC cycle aborts the operation.
        a0 = 9; b0 = 9; op0 = 2'b00;
        req0 = 1;
        tick;
        check("abort gnt0", gnt0, 32'd1);
        reset = 1'b1;
        req0 = 0;
        tick;
        check("abort pulses", {gnt1, gnt0, done1, done0, busy}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort flags", {zero, dayuling}, 32'd0);
        check("abort alu_a", alu_a, 32'd0);
        check("abort alu_op", alu_op, 32'd0);
        reset = 1'b0;
        model_last = 1'b1;
        tick;
        check("abort no done", {done1, done0, busy}, 32'd0);
        transact(1, 0, "post-reset");

        // Contention: both ports held high, winner drops on gnt and re-raises in DONE.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_last = 1'b1;
        tick;
        a0 = $urandom; b0 = $urandom; op0 = 2'($urandom);  s0 = 5'($urandom);
        a1 = $urandom; b1 = $urandom; op1 = 2'($urandom);  s1 = 5'($urandom);
        req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            w  = pick(req0, req1);
            er = w ? ref_alu(a1, b1, s1, op1) : ref_alu(a0, b0, s0, op0);
            tick;  // EXEC
            check("contend gnt", {gnt1, gnt0}, w ? 32'd2 : 32'd1);
            model_last = w;
            if (i == 3) begin
                req0 = 0; req1 = 0;
            end else if (w) begin
                req1 = 0;
            end else begin
                req0 = 0;
            end
            tick;  // DONE
            check("contend done", {done1, done0}, w ? 32'd2 : 32'd1);
            check("contend gnt low", {gnt1, gnt0}, 32'd0);
            check("contend result", result, er);
            if (i != 3) begin
                if (w) begin
                    a1 = $urandom; b1 = $urandom; op1 = 2'($urandom); s1 = 5'($urandom);
                    req1 = 1;
                end else begin
                    a0 = $urandom; b0 = $urandom; op0 = 2'($urandom); s0 = 5'($urandom);
                    req0 = 1;
                end
            end
            tick;  // IDLE
            check("contend idle", {gnt1, gnt0, done1, done0, busy}, 32'd0);
            $display("txn contend round=%0d port=%0d result=%h", i, w, result);
        end

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            pat = 2'($urandom_range(1, 3));
            a0 = $urandom; b0 = $urandom; s0 = 5'($urandom); op0 = 2'($urandom);
            a1 = $urandom; b1 = $urandom; s1 = 5'($urandom); op1 = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                b0 = a0;
                b1 = a1;
            end
            transact(pat[0], pat[1], "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
